// File: rtl/divider_seq.sv
// Sequential RV32M-style divider: restoring shift-subtract, one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and complete in one cycle.
module divider_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned      CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] div_mag;
  logic             op_rem;
  logic             neg_q;
  logic             neg_r;

  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             overflow;
  logic [WIDTH-1:0] special_res;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] iter_rem;
  logic [WIDTH-1:0] iter_quo;
  logic [WIDTH-1:0] fin_quo;
  logic [WIDTH-1:0] fin_rem;

  // Operand decode at acceptance: magnitudes and special-case detection.
  always_comb begin
    signed_op   = ~op[0];
    a_neg       = signed_op & dividend[WIDTH-1];
    b_neg       = signed_op & divisor[WIDTH-1];
    a_mag       = a_neg ? -dividend : dividend;
    b_mag       = b_neg ? -divisor : divisor;
    div_zero    = (divisor == '0);
    overflow    = signed_op & (dividend == MIN_NEG) & (divisor == ALL_ONES);
    special_res = div_zero ? (op[1] ? dividend : ALL_ONES)
                           : (op[1] ? '0 : MIN_NEG);
  end

  // One restoring step; trial[WIDTH] is the sign of the trial subtraction.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, div_mag};
    iter_rem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    iter_quo = {quo[WIDTH-2:0], ~trial[WIDTH]};
    fin_quo  = neg_q ? -iter_quo : iter_quo;
    fin_rem  = neg_r ? -iter_rem : iter_rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      div_mag <= '0;
      op_rem  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_rem  <= op[1];
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            rem     <= '0;
            quo     <= a_mag;
            div_mag <= b_mag;
            cnt     <= '0;
            busy    <= 1'b1;
            if (div_zero || overflow) begin
              result <= special_res;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state  <= CALC;
            end
          end
        end
        CALC: begin
          rem <= iter_rem;
          quo <= iter_quo;
          cnt <= cnt + CW'(1);
          // Final step folds in the sign correction so result is ready in DONE.
          if (cnt == LAST) begin
            cnt    <= '0;
            result <= op_rem ? fin_rem : fin_quo;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Directed bench for divider_seq: RV32M results, latency, busy/done timing,
// ignored starts while busy, back-to-back issue and mid-operation reset.
module tb_divider_seq;

  localparam int unsigned WIDTH = 32;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  int  n_checks = 0;
  int  n_pass   = 0;
  time t_accept;

  divider_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Present an operation for one cycle, then scramble the inputs.
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    t_accept = $time;
    #1;
    start = 1'b0;
    op = 2'($urandom); dividend = $urandom; divisor = $urandom;
  endtask

  // Wait for done; latency is the cycle offset from the start-sampling cycle.
  task automatic wait_done(input string tag, input logic [31:0] exp_res, input int exp_lat);
    int guard = 0;
    int lat;
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    while (!done && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    lat = done ? int'(($time - t_accept) / 10) + 1 : -1;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"},  result,   exp_res);
    check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    start_op(o, a, b);
    wait_done(tag, exp_res, exp_lat);
    @(posedge clk); #1;
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    check({tag, "_held"},      result,    exp_res);
  endtask

  initial begin
    int seen_done;
    rst = 1'b1; start = 1'b0; op = '0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",   32'(busy), 32'd0);
    check("reset_done",   32'(done), 32'd0);
    check("reset_result", result,    32'd0);
    @(negedge clk); rst = 1'b0;

    run_op("div_20_m3",   OP_DIV,  32'h0000_0014, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 33);
    run_op("rem_20_m3",   OP_REM,  32'h0000_0014, 32'hFFFF_FFFD, 32'h0000_0002, 33);
    run_op("rem_m20_3",   OP_REM,  32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE, 33);
    run_op("divu_max_2",  OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h7FFF_FFFF, 33);
    run_op("remu_max_2",  OP_REMU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 33);
    run_op("divu_by0",    OP_DIVU, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1);
    run_op("remu_by0",    OP_REMU, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1);
    run_op("div_by0",     OP_DIV,  32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, 1);
    run_op("rem_by0",     OP_REM,  32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 1);
    run_op("div_ovf",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",     OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    run_op("divu_ovf_pat",OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    run_op("div_zero_nd", OP_DIV,  32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0000, 33);
    run_op("remu_zero_nd",OP_REMU, 32'h0000_0000, 32'h0000_0007, 32'h0000_0000, 33);
    run_op("div_m7_2",    OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);

    // A start while busy is ignored; the next op issues in the IDLE cycle after DONE.
    start_op(OP_DIVU, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    op = OP_DIVU; dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_ignore", 32'h0000_000E, 33);
    @(posedge clk);
    start_op(OP_REMU, 32'd100, 32'd7);
    check("b2b_gap", 32'(int'(($time - t_accept) / 10)), 32'd0);
    wait_done("b2b_remu", 32'h0000_0002, 33);
    @(posedge clk); #1;

    // Reset in the middle of CALC aborts with no done pulse; start is ignored under reset.
    start_op(OP_DIV, 32'd100, 32'd7);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op = OP_DIVU; dividend = 32'd9; divisor = 32'd0;
    @(posedge clk); #1;
    check("abort_busy",   32'(busy), 32'd0);
    check("abort_done",   32'(done), 32'd0);
    check("abort_result", result,    32'd0);
    @(posedge clk); #1;
    check("abort_hold_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    seen_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen_done++;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    run_op("div_after_rst", OP_DIV, 32'd100, 32'd7, 32'h0000_000E, 33);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/divider_seq.md
DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width; equals register width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M semantics).
REQ-006 dividend  input  WIDTH  rs1 operand; sampled with start.
REQ-007 divisor  input  WIDTH  rs2 operand; sampled with start.
REQ-008 busy  output  1  high from the cycle after start is accepted until the cycle done is high, inclusive.
REQ-009 done  output  1  one-cycle pulse; result is valid in that cycle.
REQ-010 result  output  WIDTH  quotient or remainder; held until the next accepted start.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-012 IDLE with start=1: latch op and operands, busy=1 next cycle, go to CALC (normal case) or DONE (special case).
REQ-013 Special cases SHALL be detected at acceptance: divisor=0, or signed op with dividend=0x80000000 and divisor=0xFFFFFFFF.
REQ-014 CALC: restoring shift-subtract on operand magnitudes, one quotient bit per cycle, exactly WIDTH cycles, then DONE.
REQ-015 Each iteration: shift {rem,quo} left 1; trial = rem - |divisor| at WIDTH+1 bits; if trial non-negative, rem=trial and quo LSB=1, else quo LSB=0.
REQ-016 Signed ops: quotient negated when operand signs differ; remainder takes the sign of the dividend; magnitudes are computed as two's complement absolute values.
REQ-017 Unsigned ops: operands used as-is, no sign correction.
REQ-018 DONE: done=1, busy=1, result registered; next state IDLE.
REQ-019 Latency: normal case, done high in cycle N+WIDTH+1 after start is sampled in cycle N (33 cycles for WIDTH=32); special case, cycle N+1.
REQ-020 Divide by zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = dividend.
REQ-021 Signed overflow: DIV result 0x80000000; REM result 0.
REQ-022 start while busy (CALC or DONE) SHALL be ignored; latched operands and op remain unchanged.
REQ-023 start in the IDLE cycle directly after DONE SHALL be accepted (back-to-back throughput of one operation per WIDTH+2 cycles).
REQ-024 Input changes after acceptance SHALL NOT affect the in-flight result.
REQ-025 Dividend of 0 with nonzero divisor SHALL take the normal path and yield 0 for all ops.

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE, busy=0, done=0, result=0, iteration counter=0, and clear internal registers.
REQ-027 Reset asserted during CALC or DONE SHALL abort the operation with no done pulse; start is ignored while rst=1.
REQ-028 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-029 DIV 20 / -3 (0x14, 0xFFFFFFFD) -> done at start+33, result 0xFFFFFFFA; REM same operands -> 0x00000002.
REQ-030 REM -20 % 3 (0xFFFFFFEC, 0x3) -> 0xFFFFFFFE; DIVU 0xFFFFFFFF / 2 -> 0x7FFFFFFF; REMU same -> 0x00000001.
REQ-031 DIVU 0x1234 / 0 -> done at start+1, result 0xFFFFFFFF; REMU 0x1234 / 0 -> 0x00001234.
REQ-032 DIV 0x80000000 / 0xFFFFFFFF -> done at start+1, result 0x80000000; REM same -> 0x00000000.
REQ-033 Start DIVU 100/7, pulse start with 9/3 at cycle 5 -> second start ignored, result 0x0000000E at start+33; immediate back-to-back start after done -> accepted.
REQ-034 Start DIV 100/7, assert rst at cycle 10 -> busy=0, done never pulses, result 0; new DIV 100/7 after reset -> 0x0000000E.
